// File: rtl/systolic_feed_ctrl_if.sv
// Host/array-side signal bundle for systolic_feed_ctrl.
// The master modport is the command/host side, the slave modport is the sequencer.
interface systolic_feed_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 8
) ();
    logic                   start;
    logic [KW-1:0]          k_len;
    logic                   src_valid;
    logic                   busy;
    logic                   done;
    logic                   acc_clear;
    logic                   rd_en;
    logic [KW-1:0]          rd_addr;
    logic [N-1:0]           lane_valid;
    logic                   out_valid;
    logic [$clog2(N)-1:0]   out_row;

    modport master (
        output start, k_len, src_valid,
        input  busy, done, acc_clear, rd_en, rd_addr, lane_valid, out_valid, out_row
    );

    modport slave (
        input  start, k_len, src_valid,
        output busy, done, acc_clear, rd_en, rd_addr, lane_valid, out_valid, out_row
    );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for one N x N systolic-array tile: clears accumulators, streams
// k_len operand reads, produces the skewed lane-valid wavefront, waits for the
// array to drain and then steps through the N result rows.
// Optional feature macro: SYSTOLIC_CTRL_STALL_EN -- when defined, src_valid
// throttles operand reads; when undefined, src_valid is ignored (treated as 1).
module systolic_feed_ctrl #(
    parameter int N      = 4,
    parameter int KW     = 8,
    parameter int PE_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    systolic_feed_ctrl_if.slave ctl
);
    // Drain length covers the full diagonal wavefront plus the PE pipeline.
    localparam int D  = 2 * N - 1 + PE_LAT;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam int RW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_UNLOAD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [KW-1:0]   klen_r, klen_nxt_s;
    logic [KW-1:0]   feed_cnt_r, feed_cnt_nxt_s;
    logic [DW-1:0]   drain_cnt_r, drain_cnt_nxt_s;
    logic [RW-1:0]   row_cnt_r, row_cnt_nxt_s;
    logic [N-1:0]    lane_valid_r;

    logic            src_ok_s;
    logic            busy_s;
    logic            done_s;
    logic            acc_clear_s;
    logic            rd_en_s;
    logic [KW-1:0]   rd_addr_s;
    logic            out_valid_s;
    logic [RW-1:0]   out_row_s;

`ifdef SYSTOLIC_CTRL_STALL_EN
    assign src_ok_s = ctl.src_valid;
`else
    // Port kept for a uniform interface; reads never stall in this build.
    logic unused_src_valid_s;
    assign unused_src_valid_s = ctl.src_valid;
    assign src_ok_s           = 1'b1;
`endif

    // State, latched length and phase counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            klen_r      <= '0;
            feed_cnt_r  <= '0;
            drain_cnt_r <= '0;
            row_cnt_r   <= '0;
        end else begin
            state_r     <= state_nxt_s;
            klen_r      <= klen_nxt_s;
            feed_cnt_r  <= feed_cnt_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            row_cnt_r   <= row_cnt_nxt_s;
        end
    end

    // Skew register: lane 0 sees the read one cycle later (buffer latency),
    // each further lane one more cycle; it shifts every cycle without freezing.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_valid_r <= '0;
        end else begin
            lane_valid_r <= {lane_valid_r[N-2:0], rd_en_s};
        end
    end

    // Next-state, counter updates and output decode from registered state.
    always_comb begin
        state_nxt_s     = state_r;
        klen_nxt_s      = klen_r;
        feed_cnt_nxt_s  = feed_cnt_r;
        drain_cnt_nxt_s = drain_cnt_r;
        row_cnt_nxt_s   = row_cnt_r;
        busy_s          = 1'b0;
        done_s          = 1'b0;
        acc_clear_s     = 1'b0;
        rd_en_s         = 1'b0;
        rd_addr_s       = '0;
        out_valid_s     = 1'b0;
        out_row_s       = '0;

        case (state_r)
            S_IDLE: begin
                // A zero-length request is dropped without leaving IDLE.
                if (ctl.start && (ctl.k_len != '0)) begin
                    klen_nxt_s  = ctl.k_len;
                    state_nxt_s = S_CLEAR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                busy_s         = 1'b1;
                acc_clear_s    = 1'b1;
                feed_cnt_nxt_s = '0;
                state_nxt_s    = S_FEED;
            end
            S_FEED: begin
                busy_s    = 1'b1;
                rd_en_s   = src_ok_s;
                rd_addr_s = feed_cnt_r;
                if (src_ok_s) begin
                    if (feed_cnt_r == (klen_r - {{(KW-1){1'b0}}, 1'b1})) begin
                        feed_cnt_nxt_s  = '0;
                        drain_cnt_nxt_s = '0;
                        state_nxt_s     = S_DRAIN;
                    end else begin
                        feed_cnt_nxt_s = feed_cnt_r + {{(KW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    feed_cnt_nxt_s = feed_cnt_r;
                end
            end
            S_DRAIN: begin
                busy_s = 1'b1;
                if (drain_cnt_r == DW'(D - 1)) begin
                    drain_cnt_nxt_s = '0;
                    row_cnt_nxt_s   = '0;
                    state_nxt_s     = S_UNLOAD;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r + {{(DW-1){1'b0}}, 1'b1};
                end
            end
            S_UNLOAD: begin
                busy_s      = 1'b1;
                out_valid_s = 1'b1;
                out_row_s   = row_cnt_r;
                if (row_cnt_r == RW'(N - 1)) begin
                    row_cnt_nxt_s = '0;
                    state_nxt_s   = S_DONE;
                end else begin
                    row_cnt_nxt_s = row_cnt_r + {{(RW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                // start is not looked at here; only IDLE accepts work.
                done_s      = 1'b1;
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    assign ctl.busy       = busy_s;
    assign ctl.done       = done_s;
    assign ctl.acc_clear  = acc_clear_s;
    assign ctl.rd_en      = rd_en_s;
    assign ctl.rd_addr    = rd_addr_s;
    assign ctl.lane_valid = lane_valid_r;
    assign ctl.out_valid  = out_valid_s;
    assign ctl.out_row    = out_row_s;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl (N=4, KW=4, PE_LAT=1).
// Cycle 0 of each run is the cycle in which start is presented.
module tb_systolic_feed_ctrl;
    localparam int N      = 4;
    localparam int KW     = 4;
    localparam int PE_LAT = 1;
    localparam int D      = 2 * N - 1 + PE_LAT;

    logic clk = 1'b0;
    logic reset;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   ext;

    always #5 clk = ~clk;

    systolic_feed_ctrl_if #(.N(N), .KW(KW)) bus ();

    systolic_feed_ctrl #(.N(N), .KW(KW), .PE_LAT(PE_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    logic          busy_a  [0:63];
    logic          done_a  [0:63];
    logic          clr_a   [0:63];
    logic          rd_a    [0:63];
    logic          ov_a    [0:63];
    logic [KW-1:0] addr_a  [0:63];
    logic [N-1:0]  lv_a    [0:63];
    logic [1:0]    row_a   [0:63];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive nc cycles: start at cycle 0 (and st2/st3), src_valid low at stall_c,
    // reset high at rst_c; capture outputs mid-cycle.
    task automatic record(input int k, input int nc, input int stall_c,
                          input int st2, input int st3, input int rst_c);
        for (int c = 0; c < nc; c++) begin
            bus.start     = (c == 0) || (c == st2) || (c == st3);
            bus.k_len     = KW'(k);
            bus.src_valid = (c != stall_c);
            reset         = (c == rst_c);
            @(negedge clk);
            busy_a[c] = bus.busy;
            done_a[c] = bus.done;
            clr_a[c]  = bus.acc_clear;
            rd_a[c]   = bus.rd_en;
            ov_a[c]   = bus.out_valid;
            addr_a[c] = bus.rd_addr;
            lv_a[c]   = bus.lane_valid;
            row_a[c]  = bus.out_row;
            @(posedge clk);
            #1;
        end
        bus.start     = 1'b0;
        bus.src_valid = 1'b1;
        reset         = 1'b0;
    endtask

    function automatic logic exp_rd(input int c, input int last, input int x, input int stall_c);
        return (c >= 2) && (c <= last) && !((x != 0) && (c == stall_c));
    endfunction

    // Compare a recorded tile against hand-derived timing; x=1 means one stall cycle.
    task automatic check_tile(input string nm, input int k, input int x, input int stall_c, input int nc);
        int last;
        int eaddr;
        int erow;
        logic [N-1:0] elv;
        last = 1 + k + x;
        for (int c = 0; c < nc; c++) begin
            eaddr = ((c >= 2) && (c <= last)) ? (c - 2 - (((x != 0) && (c > stall_c)) ? 1 : 0)) : 0;
            erow  = ((c >= last + D + 1) && (c <= last + D + N)) ? (c - (last + D + 1)) : 0;
            for (int i = 0; i < N; i++) elv[i] = exp_rd(c - 1 - i, last, x, stall_c);
            check($sformatf("%s busy c%0d", nm, c), 32'(busy_a[c]), 32'((c >= 1) && (c <= last + D + N)));
            check($sformatf("%s done c%0d", nm, c), 32'(done_a[c]), 32'(c == last + D + N + 1));
            check($sformatf("%s acc_clear c%0d", nm, c), 32'(clr_a[c]), 32'(c == 1));
            check($sformatf("%s rd_en c%0d", nm, c), 32'(rd_a[c]), 32'(exp_rd(c, last, x, stall_c)));
            check($sformatf("%s rd_addr c%0d", nm, c), 32'(addr_a[c]), 32'(eaddr));
            check($sformatf("%s lane_valid c%0d", nm, c), 32'(lv_a[c]), 32'(elv));
            check($sformatf("%s out_valid c%0d", nm, c), 32'(ov_a[c]),
                  32'((c >= last + D + 1) && (c <= last + D + N)));
            check($sformatf("%s out_row c%0d", nm, c), 32'(row_a[c]), 32'(erow));
        end
    endtask

    initial begin
        int done_cnt;
`ifdef SYSTOLIC_CTRL_STALL_EN
        ext = 1;
`else
        ext = 0;
`endif
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.src_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset acc_clear", 32'(bus.acc_clear), 32'd0);
        check("reset rd_en", 32'(bus.rd_en), 32'd0);
        check("reset rd_addr", 32'(bus.rd_addr), 32'd0);
        check("reset lane_valid", 32'(bus.lane_valid), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_row", 32'(bus.out_row), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic tile, k_len=3.
        record(3, 22, -1, -1, -1, -1);
        check_tile("basic", 3, 0, -1, 22);
        check("basic lv0 c3", 32'(lv_a[3][0]), 32'd1);
        check("basic lv3 c8", 32'(lv_a[8][3]), 32'd1);

        // One stalled FEED cycle at cycle 3.
        record(3, 25, 3, -1, -1, -1);
        check_tile("stall", 3, ext, 3, 25);

        // Zero-length start is dropped.
        record(0, 6, -1, -1, -1, -1);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("klen0 busy c%0d", c), 32'(busy_a[c]), 32'd0);
            check($sformatf("klen0 rd_en c%0d", c), 32'(rd_a[c]), 32'd0);
        end

        // Extra starts during FEED (c3) and DONE (c17) are ignored.
        record(3, 30, -1, 3, 17, -1);
        check_tile("restart", 3, 0, -1, 30);
        done_cnt = 0;
        for (int c = 0; c < 30; c++) done_cnt += int'(done_a[c]);
        check("restart done pulses", 32'(done_cnt), 32'd1);

        // Reset during DRAIN (cycle 6) flushes everything.
        record(3, 24, -1, -1, -1, 6);
        check("midrst lane_valid c6", 32'(lv_a[6]), 32'hE);
        check("midrst busy c6", 32'(busy_a[6]), 32'd1);
        for (int c = 7; c < 24; c++) begin
            check($sformatf("midrst busy c%0d", c), 32'(busy_a[c]), 32'd0);
            check($sformatf("midrst lane_valid c%0d", c), 32'(lv_a[c]), 32'd0);
            check($sformatf("midrst done c%0d", c), 32'(done_a[c]), 32'd0);
            check($sformatf("midrst out_valid c%0d", c), 32'(ov_a[c]), 32'd0);
            check($sformatf("midrst rd_en c%0d", c), 32'(rd_a[c]), 32'd0);
        end
        record(3, 22, -1, -1, -1, -1);
        check_tile("postrst", 3, 0, -1, 22);

        // Maximum length for KW=4.
        record(15, 34, -1, -1, -1, -1);
        check_tile("maxlen", 15, 0, -1, 34);
        check("maxlen addr c16", 32'(addr_a[16]), 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for one N×N systolic-array tile. On `start` it clears the PE accumulators and streams `k_len` operand reads from the operand buffer. It generates the skewed per-lane valid wavefront that travels alongside the operand delay lines, waits for the array to drain, then steps through the N result rows. It sits between the host/command logic and the array plus its input skew delay chains.

## Interface

Parameters:
- `N`, 4: array dimension (lanes/rows), N ≥ 2
- `KW`, 8: width of `k_len` and `rd_addr`
- `PE_LAT`, 1: PE multiply-accumulate latency in cycles, ≥ 1

Ports:
- `clk` input 1: clock, all logic on rising edge
- `reset` input 1: synchronous, active-high reset
- `start` input 1: request a tile computation; sampled only in IDLE
- `k_len` input KW: inner-product length; latched on accepted `start`
- `src_valid` input 1: operand buffer has data for the current address
- `busy` output 1: tile in progress
- `done` output 1: one-cycle completion pulse
- `acc_clear` output 1: clear all PE accumulators
- `rd_en` output 1: operand buffer read strobe
- `rd_addr` output KW: operand buffer read address
- `lane_valid` output N: bit i = data valid entering lane i (skewed)
- `out_valid` output 1: result row present on array outputs
- `out_row` output $clog2(N): index of the result row being unloaded

## Operation

States: IDLE, CLEAR, FEED, DRAIN, UNLOAD, DONE.
- IDLE: `start`=1 and `k_len`≠0 → latch `k_len`, go to CLEAR. `start` with `k_len`=0 is ignored, with no state change. `start` outside IDLE is ignored.
- CLEAR: one cycle, `acc_clear`=1 → FEED.
- FEED: `rd_en` = `src_valid`, `rd_addr` = feed count (starts at 0). Count increments only when `rd_en`=1. When `rd_en`=1 with count = `k_len`−1 → DRAIN, and count returns to 0.
- DRAIN: exactly D = 2N−1+`PE_LAT` cycles → UNLOAD.
- UNLOAD: N cycles, `out_valid`=1, `out_row` = 0…N−1 → DONE.
- DONE: one cycle, `done`=1, `busy`=0 → IDLE. A `start` in the DONE cycle is ignored.

Other rules:
- `busy`=1 in CLEAR, FEED, DRAIN and UNLOAD; 0 otherwise.
- Skew register: `lane_valid[0]` is `rd_en` registered by one cycle, matching the buffer's 1-cycle read latency. `lane_valid[i]` is `lane_valid[i-1]` registered by one cycle.
- The skew register shifts every cycle in all states and never freezes. A stalled FEED cycle injects a 0 bubble.
- Internal counters are sized to reach `k_len`−1, D−1 and N−1 without overflow. `rd_addr` never wraps within a tile, because the maximum address is `k_len`−1 ≤ 2^KW−2.
- Reset at any time, including mid-tile: state goes to IDLE and every output and counter goes to 0. This includes clearing the skew register, so no stale lane_valid bits remain.

## Timing

- Reset values: `busy`, `done`, `acc_clear`, `rd_en`, `rd_addr`, `lane_valid`, `out_valid` and `out_row` are all 0.
- `start` accepted at edge t: CLEAR during cycle t+1, first FEED cycle t+2.
- With no stalls, FEED spans `k_len` cycles and DRAIN starts in the cycle after the last read.
- The last lane-(N−1) valid occurs N cycles after the last `rd_en`. Since D ≥ N, that valid always falls inside DRAIN.
- Total busy cycles with no stalls = 1 + `k_len` + D + N. `done` follows in the next cycle.
- All outputs are decoded from registered state and counters. There is no combinational path from inputs to outputs except `rd_en` from `src_valid` in FEED.

## Configuration

- `SYSTOLIC_CTRL_STALL_EN` defined: `src_valid` is honoured as described above.
- `SYSTOLIC_CTRL_STALL_EN` undefined: `src_valid` is ignored and treated as 1. FEED then always lasts exactly `k_len` cycles and the port remains present but unused.

## Test plan

- Basic tile, N=4, PE_LAT=1, k_len=3, `start` at cycle 0, no stalls:
  - `acc_clear` in cycle 1
  - `rd_en` in cycles 2–4 with `rd_addr` 0, 1, 2
  - `lane_valid[0]` in cycles 3–5 and `lane_valid[3]` in cycles 6–8
  - DRAIN in cycles 5–12, `out_valid` in cycles 13–16 with `out_row` 0–3
  - `done` in cycle 17; `busy` high in cycles 1–16
- Stall (macro defined), same setup with `src_valid`=0 in cycle 3:
  - `rd_addr` holds at 1 through cycle 3 and reads complete in cycle 5
  - `lane_valid[0]` is 1, 0, 1, 1 in cycles 3–6
  - the 0 bubble appears at `lane_valid[3]` in cycle 7; `done` in cycle 18
- Stall ignored (macro undefined), same stall stimulus: timing is identical to the basic tile.
- Ignored starts:
  - `start` with k_len=0 in IDLE → `busy` stays 0
  - `start` pulses during FEED and during DONE → no second tile, and `done` pulses exactly once
- Reset mid-tile: `reset` for 1 cycle during DRAIN → all outputs 0 on the next cycle, `lane_valid` all 0. A new `start` then reproduces the basic-tile timing.
- Maximum length, KW=4, k_len=15: `rd_addr` steps 0–14 with no wrap, and `busy` lasts 1+15+8+4 = 28 cycles.
